transfer_datapath: RTL and testbench

- Register/transfer datapath directly downstream of the control unit.
- Executes the 4-bit transfer command, the PC increment and the SP inc/dec every clock, holding the architectural registers PC, SP, MA, MD, IR, A and AP.
- Drives the memory address/data bus, feeds IR (opcode) back to the control unit, and provides the A/AP/MD operands to the ALU.
- Owns the IN/OUT port handshakes.

---
 rtl/edulent_pkg.sv | 29 ++
 rtl/transfer_datapath_io_port.sv | 59 +++++
 rtl/transfer_datapath.sv | 123 ++++++++++++
 tb/tb_transfer_datapath.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edulent_pkg.sv
// Shared types and constants for the control unit / transfer datapath pair.
package edulent_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 8;

    localparam logic [1:0] SP_INC = 2'b01;
    localparam logic [1:0] SP_DEC = 2'b10;

    typedef enum logic [3:0] {
        CMD_NOP    = 4'h0,
        CMD_MA_PC  = 4'h1,
        CMD_MD_MEM = 4'h2,
        CMD_IR_MD  = 4'h3,
        CMD_MA_MD  = 4'h4,
        CMD_A_MD   = 4'h5,
        CMD_MA_AP  = 4'h6,
        CMD_MA_SP  = 4'h7,
        CMD_MD_A   = 4'h8,
        CMD_WRITE  = 4'h9,
        CMD_A_ALU  = 4'hA,
        CMD_PC_MD  = 4'hB,
        CMD_IN     = 4'hC,
        CMD_OUT    = 4'hD,
        CMD_PC_AP  = 4'hE,
        CMD_MD_PC  = 4'hF
    } transfer_cmd_t;

endpackage

// File: rtl/transfer_datapath_io_port.sv
// IN/OUT port handshakes: IN ack pulse and underrun flag, OUT valid/ready holding register and overrun flag.
module io_port #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              do_in,
    input  logic              do_out,
    input  logic              in_valid,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] out_wdata,
    output logic              in_ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              in_underrun,
    output logic              out_overrun
);

    logic              in_ack_nxt;
    logic [DATA_W-1:0] out_data_nxt;
    logic              out_valid_nxt;
    logic              in_underrun_nxt;
    logic              out_overrun_nxt;
    logic              accept;

    always_comb begin
        in_ack_nxt      = do_in && in_valid;
        in_underrun_nxt = in_underrun || (do_in && !in_valid);
        out_data_nxt    = out_data;
        out_valid_nxt   = out_valid;
        out_overrun_nxt = out_overrun;
        accept          = out_valid && out_ready;
        if (do_out) begin
            // A word accepted this cycle frees the slot, so the new one is not an overrun.
            out_data_nxt    = out_wdata;
            out_valid_nxt   = 1'b1;
            out_overrun_nxt = out_overrun || (out_valid && !accept);
        end else if (accept) begin
            out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            in_ack      <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            in_underrun <= 1'b0;
            out_overrun <= 1'b0;
        end else begin
            in_ack      <= in_ack_nxt;
            out_data    <= out_data_nxt;
            out_valid   <= out_valid_nxt;
            in_underrun <= in_underrun_nxt;
            out_overrun <= out_overrun_nxt;
        end
    end

endmodule

// File: rtl/transfer_datapath.sv
// Architectural register file and transfer-command decode downstream of the control unit.
module transfer_datapath
    import edulent_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned PC_RST = 0,
    parameter int unsigned SP_RST = 2**ADDR_W - 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_transfer_cmd,
    input  logic              i_inc_pc,
    input  logic [1:0]        i_inc_dec_sp,
    input  logic              i_ap_sel,
    input  logic              i_mem_write_enable,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic [7:0]        o_ir,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_ap,
    output logic [DATA_W-1:0] o_md,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_sp,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ack,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_in_underrun,
    output logic              o_out_overrun
);

    transfer_cmd_t     cmd;
    logic [ADDR_W-1:0] pc, sp, ma;
    logic [ADDR_W-1:0] pc_nxt, sp_nxt, ma_nxt;
    logic [DATA_W-1:0] md, a, ap;
    logic [DATA_W-1:0] md_nxt, a_nxt, ap_nxt;
    logic [7:0]        ir, ir_nxt;

    assign cmd = transfer_cmd_t'(i_transfer_cmd);

    // Next-state decode; all transfers read pre-edge register values.
    always_comb begin
        pc_nxt = i_inc_pc ? pc + ADDR_W'(1) : pc;
        ma_nxt = ma;
        md_nxt = md;
        ir_nxt = ir;
        a_nxt  = a;
        ap_nxt = ap;
        unique case (i_inc_dec_sp)
            SP_INC:  sp_nxt = sp + ADDR_W'(1);
            SP_DEC:  sp_nxt = sp - ADDR_W'(1);
            default: sp_nxt = sp;
        endcase
        case (cmd)
            CMD_MA_PC:  ma_nxt = pc;
            CMD_MD_MEM: md_nxt = i_mem_rdata;
            CMD_IR_MD:  ir_nxt = 8'(md);
            CMD_MA_MD:  ma_nxt = ADDR_W'(md);
            CMD_A_MD:   if (i_ap_sel) ap_nxt = md; else a_nxt = md;
            CMD_MA_AP:  ma_nxt = ADDR_W'(ap);
            CMD_MA_SP:  ma_nxt = sp;
            CMD_MD_A:   md_nxt = i_ap_sel ? ap : a;
            CMD_A_ALU:  if (i_ap_sel) ap_nxt = i_alu_result; else a_nxt = i_alu_result;
            CMD_PC_MD:  pc_nxt = ADDR_W'(md);
            CMD_IN:     a_nxt = i_in_valid ? i_in_data : '0;
            CMD_PC_AP:  pc_nxt = ADDR_W'(ap);
            CMD_MD_PC:  md_nxt = DATA_W'(pc);
            default:    ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc <= ADDR_W'(PC_RST);
            sp <= ADDR_W'(SP_RST);
            ma <= '0;
            md <= '0;
            ir <= '0;
            a  <= '0;
            ap <= '0;
        end else begin
            pc <= pc_nxt;
            sp <= sp_nxt;
            ma <= ma_nxt;
            md <= md_nxt;
            ir <= ir_nxt;
            a  <= a_nxt;
            ap <= ap_nxt;
        end
    end

    io_port #(.DATA_W(DATA_W)) u_io_port (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .do_in       (cmd == CMD_IN),
        .do_out      (cmd == CMD_OUT),
        .in_valid    (i_in_valid),
        .out_ready   (i_out_ready),
        .out_wdata   (a),
        .in_ack      (o_in_ack),
        .out_data    (o_out_data),
        .out_valid   (o_out_valid),
        .in_underrun (o_in_underrun),
        .out_overrun (o_out_overrun)
    );

    assign o_mem_addr  = ma;
    assign o_mem_wdata = md;
    assign o_mem_we    = i_mem_write_enable;
    assign o_ir        = ir;
    assign o_a         = a;
    assign o_ap        = ap;
    assign o_md        = md;
    assign o_pc        = pc;
    assign o_sp        = sp;

endmodule

// File: tb/tb_transfer_datapath.sv
// Bench for transfer_datapath: directed scenarios with literal expectations plus randomized traffic vs a behavioural model.
module tb_transfer_datapath;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cmd = '0;
    logic       inc_pc = 1'b0;
    logic [1:0] sp_op = '0;
    logic       ap_sel = 1'b0;
    logic       mem_we = 1'b0;
    logic [7:0] alu = '0;
    logic [7:0] rdata = '0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic [7:0] mem_addr, mem_wdata, ir, a, ap, md, pc, sp, out_data;
    logic       we_o, in_ack, out_valid, in_underrun, out_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state of the machine's visible registers.
    logic [7:0] m_pc, m_sp, m_ma, m_md, m_ir, m_a, m_ap, m_od;
    logic       m_ack, m_ov, m_und, m_ovr;

    always #5 clk = ~clk;

    transfer_datapath dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_transfer_cmd     (cmd),
        .i_inc_pc           (inc_pc),
        .i_inc_dec_sp       (sp_op),
        .i_ap_sel           (ap_sel),
        .i_mem_write_enable (mem_we),
        .i_alu_result       (alu),
        .i_mem_rdata        (rdata),
        .o_mem_addr         (mem_addr),
        .o_mem_wdata        (mem_wdata),
        .o_mem_we           (we_o),
        .o_ir               (ir),
        .o_a                (a),
        .o_ap               (ap),
        .o_md               (md),
        .o_pc               (pc),
        .o_sp               (sp),
        .i_in_data          (in_data),
        .i_in_valid         (in_valid),
        .o_in_ack           (in_ack),
        .o_out_data         (out_data),
        .o_out_valid        (out_valid),
        .i_out_ready        (out_ready),
        .o_in_underrun      (in_underrun),
        .o_out_overrun      (out_overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_sp = 8'hFF; m_ma = 0; m_md = 0; m_ir = 0; m_a = 0; m_ap = 0;
        m_od = 0; m_ack = 0; m_ov = 0; m_und = 0; m_ovr = 0;
    endtask

    // One clock of the architectural rules, applied to pre-edge values.
    task automatic model_clk();
        logic [7:0] pc0, sp0, md0, a0, ap0;
        logic       accepted;
        pc0 = m_pc; sp0 = m_sp; md0 = m_md; a0 = m_a; ap0 = m_ap;
        accepted = m_ov && out_ready;
        if (cmd == 4'hB)      m_pc = md0;
        else if (cmd == 4'hE) m_pc = ap0;
        else if (inc_pc)      m_pc = 8'((int'(pc0) + 1) % 256);
        if (sp_op == 2'b01)      m_sp = 8'((int'(sp0) + 1) % 256);
        else if (sp_op == 2'b10) m_sp = 8'((int'(sp0) + 255) % 256);
        if (cmd == 4'h1) m_ma = pc0;
        if (cmd == 4'h4) m_ma = md0;
        if (cmd == 4'h6) m_ma = ap0;
        if (cmd == 4'h7) m_ma = sp0;
        if (cmd == 4'h2) m_md = rdata;
        if (cmd == 4'h8) m_md = ap_sel ? ap0 : a0;
        if (cmd == 4'hF) m_md = pc0;
        if (cmd == 4'h3) m_ir = md0;
        if (cmd == 4'h5 &&  ap_sel) m_ap = md0;
        if (cmd == 4'h5 && !ap_sel) m_a  = md0;
        if (cmd == 4'hA &&  ap_sel) m_ap = alu;
        if (cmd == 4'hA && !ap_sel) m_a  = alu;
        if (cmd == 4'hC) m_a = in_valid ? in_data : 8'h00;
        m_ack = (cmd == 4'hC) && in_valid;
        if (cmd == 4'hC && !in_valid) m_und = 1'b1;
        if (cmd == 4'hD) begin
            if (m_ov && !accepted) m_ovr = 1'b1;
            m_od = a0;
            m_ov = 1'b1;
        end else if (accepted) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("sp", 32'(sp), 32'(m_sp));
        chk("mem_addr", 32'(mem_addr), 32'(m_ma));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_md));
        chk("md", 32'(md), 32'(m_md));
        chk("ir", 32'(ir), 32'(m_ir));
        chk("a", 32'(a), 32'(m_a));
        chk("ap", 32'(ap), 32'(m_ap));
        chk("mem_we", 32'(we_o), 32'(mem_we));
        chk("in_ack", 32'(in_ack), 32'(m_ack));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("in_underrun", 32'(in_underrun), 32'(m_und));
        chk("out_overrun", 32'(out_overrun), 32'(m_ovr));
    endtask

    task automatic step();
        @(posedge clk);
        model_clk();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [3:0] c, input logic ip, input logic [1:0] so,
                         input logic aps, input logic [7:0] rd);
        cmd = c; inc_pc = ip; sp_op = so; ap_sel = aps; rdata = rd;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        cmd = 0; inc_pc = 0; sp_op = 0; ap_sel = 0; mem_we = 0;
        in_valid = 0; out_ready = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_sp", 32'(sp), 32'hFF);
        chk("rst_out_valid", 32'(out_valid), 32'h0);

        // Fetch
        drive(4'h1, 0, 2'b00, 0, 8'h00);
        drive(4'h2, 1, 2'b00, 0, 8'h19);
        drive(4'h3, 0, 2'b00, 0, 8'h00);
        chk("fetch_ma", 32'(mem_addr), 32'h00);
        chk("fetch_md", 32'(md), 32'h19);
        chk("fetch_pc", 32'(pc), 32'h01);
        chk("fetch_ir", 32'(ir), 32'h19);

        // Stack wrap
        do_reset();
        drive(4'h0, 0, 2'b01, 0, 8'h00);
        chk("sp_wrap_up", 32'(sp), 32'h00);
        drive(4'h7, 0, 2'b10, 0, 8'h00);
        chk("sp_wrap_down", 32'(sp), 32'hFF);
        chk("ma_old_sp", 32'(mem_addr), 32'h00);
        drive(4'h0, 0, 2'b10, 0, 8'h00);
        chk("sp_dec2", 32'(sp), 32'hFE);

        // Jump priority
        drive(4'h2, 0, 2'b00, 0, 8'h42);
        drive(4'hB, 1, 2'b00, 0, 8'h00);
        chk("jump_md", 32'(pc), 32'h42);
        drive(4'h2, 0, 2'b00, 0, 8'h10);
        drive(4'h5, 0, 2'b00, 1, 8'h00);
        drive(4'hE, 1, 2'b00, 0, 8'h00);
        chk("jump_ap", 32'(pc), 32'h10);

        // ALU writeback
        drive(4'h2, 0, 2'b00, 0, 8'h03);
        drive(4'h5, 0, 2'b00, 0, 8'h00);
        alu = 8'h5A;
        drive(4'hA, 0, 2'b00, 1, 8'h00);
        chk("alu_ap", 32'(ap), 32'h5A);
        chk("alu_a_hold", 32'(a), 32'h03);
        drive(4'h8, 0, 2'b00, 0, 8'h00);
        chk("md_from_a", 32'(md), 32'h03);
        chk("wdata_from_a", 32'(mem_wdata), 32'h03);

        // IN port
        in_valid = 1; in_data = 8'h7E;
        drive(4'hC, 0, 2'b00, 0, 8'h00);
        chk("in_a", 32'(a), 32'h7E);
        chk("in_ack_hi", 32'(in_ack), 32'h1);
        in_valid = 0;
        drive(4'h0, 0, 2'b00, 0, 8'h00);
        chk("in_ack_lo", 32'(in_ack), 32'h0);
        drive(4'hC, 0, 2'b00, 0, 8'h00);
        chk("underrun_a", 32'(a), 32'h00);
        chk("underrun_flag", 32'(in_underrun), 32'h1);
        chk("underrun_noack", 32'(in_ack), 32'h0);

        // OUT port
        drive(4'h2, 0, 2'b00, 0, 8'h11);
        drive(4'h5, 0, 2'b00, 0, 8'h00);
        out_ready = 0;
        drive(4'hD, 0, 2'b00, 0, 8'h00);
        chk("out_valid1", 32'(out_valid), 32'h1);
        chk("out_data1", 32'(out_data), 32'h11);
        drive(4'h2, 0, 2'b00, 0, 8'h22);
        drive(4'h5, 0, 2'b00, 0, 8'h00);
        drive(4'hD, 0, 2'b00, 0, 8'h00);
        chk("out_data2", 32'(out_data), 32'h22);
        chk("overrun_flag", 32'(out_overrun), 32'h1);
        out_ready = 1;
        drive(4'h0, 0, 2'b00, 0, 8'h00);
        chk("out_drained", 32'(out_valid), 32'h0);
        drive(4'hD, 0, 2'b00, 0, 8'h00);
        chk("out_pending", 32'(out_valid), 32'h1);
        do_reset();
        chk("rst_discard", 32'(out_valid), 32'h0);
        chk("rst_overrun", 32'(out_overrun), 32'h0);

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            cmd       = 4'($urandom_range(0, 15));
            inc_pc    = 1'($urandom_range(0, 1));
            sp_op     = 2'($urandom_range(0, 3));
            ap_sel    = 1'($urandom_range(0, 1));
            mem_we    = 1'($urandom_range(0, 1));
            alu       = 8'($urandom);
            rdata     = 8'($urandom);
            in_data   = 8'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
